// File: rtl/jtkicker_psgbridge.sv
// jtkicker_psgbridge: write bridge between the 6809 main bus and NCH
// SN76489-compatible PSGs. Each chip has a data latch, a small FIFO of
// pending writes and a wr_n/ready handshake FSM. The CPU is stalled only
// when a chip's FIFO is full.
//
// Parameters:
//   NCH - number of PSG chips (1-4)
//   QAW - FIFO address width, depth = 2**QAW entries per chip
//
// Ports:
//   clk, rst          - 24 MHz clock, asynchronous active-high reset
//   cpu_cen           - CPU bus clock enable (all CPU-side sampling)
//   latch_cs[NCH]     - data latch select per chip
//   trig_cs[NCH]      - write trigger select per chip (rising-edge detected)
//   cpu_dout[8]       - CPU write data
//   cpu_wait          - combinational: CPU must hold its cycle (push blocked)
//   psg_din[8*NCH]    - data to chip i on bits [8i+7:8i]
//   psg_wrn[NCH]      - active-low write strobe per chip
//   psg_rdy[NCH]      - chip ready (high = idle)
//   busy[NCH]         - queue non-empty or handshake in progress
//   err[NCH]          - sticky handshake timeout flag
//
// Build option: JTKICKER_PSGTOUT_EN adds an 8-bit handshake timeout per chip
// (255 clk). Without it the FSM waits indefinitely and err is tied low.

module jtkicker_psgbridge #(
  parameter int unsigned NCH = 2,
  parameter int unsigned QAW = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cpu_cen,
  input  logic [NCH-1:0]   latch_cs,
  input  logic [NCH-1:0]   trig_cs,
  input  logic [7:0]       cpu_dout,
  output logic             cpu_wait,
  output logic [8*NCH-1:0] psg_din,
  output logic [NCH-1:0]   psg_wrn,
  input  logic [NCH-1:0]   psg_rdy,
  output logic [NCH-1:0]   busy,
  output logic [NCH-1:0]   err
);

  localparam int unsigned DEPTH = 2**QAW;
  localparam int unsigned CW    = QAW + 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    STROBE  = 2'd1,
    RELEASE = 2'd2
  } state_t;

  logic [NCH-1:0] wait_c;

  assign cpu_wait = |wait_c;

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic [7:0]     latch_q;
    logic           trig_q;
    logic           pend_q;
    logic [7:0]     pend_val_q;
    logic [QAW-1:0] wr_ptr_q;
    logic [QAW-1:0] rd_ptr_q;
    logic [CW-1:0]  count_q;
    logic [7:0]     mem_q [DEPTH];
    state_t         state_q;
    logic           wrn_q;
    logic [7:0]     din_q;

    logic           push_new;
    logic           req;
    logic [7:0]     req_val;
    logic           full;
    logic           pop;
    logic           accept;

    // Push request: new trigger edge or a previously blocked push.
    // While a push is pending the CPU is stalled, so new edges are ignored.
    always_comb begin
      push_new = cpu_cen & trig_cs[i] & ~trig_q;
      req      = pend_q | push_new;
      req_val  = pend_q ? pend_val_q : (latch_cs[i] ? cpu_dout : latch_q);
      full     = (count_q == CW'(DEPTH));
      pop      = (state_q == IDLE) && (count_q != '0) && psg_rdy[i];
      accept   = req & (~full | pop);
    end

    // A pending push keeps cpu_wait high through the clk that accepts it.
    assign wait_c[i] = pend_q | (push_new & full & ~pop);

    // CPU-side capture and FIFO bookkeeping.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        latch_q    <= 8'd0;
        trig_q     <= 1'b0;
        pend_q     <= 1'b0;
        pend_val_q <= 8'd0;
        wr_ptr_q   <= '0;
        rd_ptr_q   <= '0;
        count_q    <= '0;
      end else begin
        if (cpu_cen) begin
          trig_q <= trig_cs[i];
          if (latch_cs[i]) latch_q <= cpu_dout;
        end
        if (accept) wr_ptr_q <= wr_ptr_q + QAW'(1);
        if (pop)    rd_ptr_q <= rd_ptr_q + QAW'(1);
        count_q <= count_q + CW'(accept) - CW'(pop);
        pend_q  <= req & ~accept;
        if (req & ~accept) pend_val_q <= req_val;
      end
    end

    // FIFO storage, contents are don't-care until written.
    always_ff @(posedge clk) begin
      if (accept) mem_q[wr_ptr_q] <= req_val;
    end

`ifdef JTKICKER_PSGTOUT_EN
    logic [7:0] tout_q;
    logic       err_q;
    logic       advance;

    assign advance = ((state_q == STROBE)  & ~psg_rdy[i]) |
                     ((state_q == RELEASE) &  psg_rdy[i]);
    assign err[i]  = err_q;
`else
    assign err[i]  = 1'b0;
`endif

    // Handshake FSM: pop -> wrn low until ready falls -> wait ready high.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state_q <= IDLE;
        wrn_q   <= 1'b1;
        din_q   <= 8'd0;
`ifdef JTKICKER_PSGTOUT_EN
        tout_q  <= 8'd0;
        err_q   <= 1'b0;
`endif
      end else begin
        case (state_q)
          IDLE: begin
            if (pop) begin
              din_q   <= mem_q[rd_ptr_q];
              wrn_q   <= 1'b0;
              state_q <= STROBE;
            end
          end
          STROBE: begin
            if (!psg_rdy[i]) begin
              wrn_q   <= 1'b1;
              state_q <= RELEASE;
            end
          end
          RELEASE: begin
            if (psg_rdy[i]) state_q <= IDLE;
          end
          default: begin
            wrn_q   <= 1'b1;
            state_q <= IDLE;
          end
        endcase
`ifdef JTKICKER_PSGTOUT_EN
        // Counter restarts on every phase change; 255 stuck clk aborts.
        tout_q <= ((state_q == IDLE) || advance) ? 8'd0 : tout_q + 8'd1;
        if ((state_q != IDLE) && !advance && (tout_q == 8'd254)) begin
          wrn_q   <= 1'b1;
          err_q   <= 1'b1;
          state_q <= IDLE;
          tout_q  <= 8'd0;
        end
`endif
      end
    end

    assign psg_din[8*i +: 8] = din_q;
    assign psg_wrn[i]        = wrn_q;
    assign busy[i]           = (count_q != '0) | (state_q != IDLE);
  end

endmodule

// File: tb/tb_jtkicker_psgbridge.sv
// Self-checking bench for jtkicker_psgbridge (NCH=2, QAW=2). A behavioural
// PSG model answers each wrn strobe; a per-chip scoreboard holds expected
// write data, compared whenever a wrn falling edge is observed.

module tb_jtkicker_psgbridge;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cpu_cen = 1'b0;
  logic [1:0]  latch_cs = 2'b00;
  logic [1:0]  trig_cs = 2'b00;
  logic [7:0]  cpu_dout = 8'h00;
  logic        cpu_wait;
  logic [15:0] psg_din;
  logic [1:0]  psg_wrn;
  logic [1:0]  psg_rdy;
  logic [1:0]  busy;
  logic [1:0]  err;

  logic [1:0]  force_lo = 2'b00;
  logic [1:0]  force_hi = 2'b00;
  logic [1:0]  model_rdy;
  int          phase [2];
  int          cnt [2];

  int          checks = 0;
  int          errors = 0;
  logic [7:0]  exp0 [$];
  logic [7:0]  exp1 [$];
  int          pulses [2];
  logic [1:0]  prev_wrn = 2'b11;

  typedef struct {
    int         chip;
    logic [7:0] pre;
    logic       byp;
    logic [7:0] dout;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs [4];

  jtkicker_psgbridge #(.NCH(2), .QAW(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .cpu_cen  (cpu_cen),
    .latch_cs (latch_cs),
    .trig_cs  (trig_cs),
    .cpu_dout (cpu_dout),
    .cpu_wait (cpu_wait),
    .psg_din  (psg_din),
    .psg_wrn  (psg_wrn),
    .psg_rdy  (psg_rdy),
    .busy     (busy),
    .err      (err)
  );

  always #5 clk = ~clk;

  assign psg_rdy = force_hi | (model_rdy & ~force_lo);

  // PSG model: ready falls ~3 clk after wrn low, rises 32 clk later.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      model_rdy <= 2'b11;
      for (int i = 0; i < 2; i++) begin
        phase[i] <= 0;
        cnt[i]   <= 0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        case (phase[i])
          0: if (!psg_wrn[i]) begin phase[i] <= 1; cnt[i] <= 1; end
          1: if (cnt[i] == 3) begin model_rdy[i] <= 1'b0; phase[i] <= 2; cnt[i] <= 1; end
             else cnt[i] <= cnt[i] + 1;
          default: if (cnt[i] == 32) begin model_rdy[i] <= 1'b1; phase[i] <= 0; end
                   else cnt[i] <= cnt[i] + 1;
        endcase
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // Advance one clk, sample at the falling edge, score any new wrn strobe.
  task automatic tick();
    logic [7:0] e;
    logic       empty;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      if (prev_wrn[i] && !psg_wrn[i]) begin
        pulses[i]++;
        empty = (i == 0) ? (exp0.size() == 0) : (exp1.size() == 0);
        if (empty) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write chip%0d: got write 0x%02h, required none", i, psg_din[8*i +: 8]);
        end else begin
          if (i == 0) e = exp0.pop_front();
          else        e = exp1.pop_front();
          check($sformatf("psg_din%0d", i), 32'(psg_din[8*i +: 8]), 32'(e));
        end
      end
    end
    prev_wrn = psg_wrn;
  endtask

  // One CPU bus cycle: cpu_cen high one clk, then three idle clk.
  task automatic cpu_cyc(input logic [1:0] lcs, input logic [1:0] tcs, input logic [7:0] d);
    latch_cs = lcs;
    trig_cs  = tcs;
    cpu_dout = d;
    cpu_cen  = 1'b1;
    tick();
    cpu_cen  = 1'b0;
    tick();
    tick();
    tick();
  endtask

  task automatic push_exp(input int chip, input logic [7:0] v);
    if (chip == 0) exp0.push_back(v);
    else           exp1.push_back(v);
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while ((busy != 2'b00 || psg_rdy != 2'b11) && n < budget) begin
      tick();
      n++;
    end
    check("drain_busy", 32'(busy), 32'h0);
  endtask

  initial begin
    logic [1:0] mask;
    logic       both_low;
    int         n;

    vecs[0] = '{0, 8'h9F, 1'b0, 8'hE7, 8'h9F};
    vecs[1] = '{1, 8'h3C, 1'b0, 8'hC3, 8'h3C};
    vecs[2] = '{0, 8'h11, 1'b1, 8'h55, 8'h55};
    vecs[3] = '{1, 8'h80, 1'b1, 8'h07, 8'h07};
    pulses[0] = 0;
    pulses[1] = 0;

    // Reset state
    tick();
    tick();
    check("rst_wrn", 32'(psg_wrn), 32'h3);
    check("rst_din", 32'(psg_din), 32'h0);
    check("rst_wait", 32'(cpu_wait), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_err", 32'(err), 32'h0);
    rst = 1'b0;
    tick();
    tick();

    // Single writes: plain latch-then-trigger and same-cycle bypass
    for (int v = 0; v < 4; v++) begin
      mask = 2'b01 << vecs[v].chip;
      pulses[0] = 0;
      pulses[1] = 0;
      cpu_cyc(mask, 2'b00, vecs[v].pre);
      push_exp(vecs[v].chip, vecs[v].exp);
      if (vecs[v].byp) cpu_cyc(mask, mask, vecs[v].dout);
      else             cpu_cyc(2'b00, mask, vecs[v].dout);
      check($sformatf("vec%0d_wait", v), 32'(cpu_wait), 32'h0);
      cpu_cyc(2'b00, 2'b00, 8'h00);
      wait_idle(300);
      check($sformatf("vec%0d_pulses", v), 32'(pulses[vecs[v].chip]), 32'd1);
      check($sformatf("vec%0d_other", v), 32'(pulses[1 - vecs[v].chip]), 32'd0);
      check($sformatf("vec%0d_sb", v), 32'(exp0.size() + exp1.size()), 32'd0);
    end

    // Held trigger: exactly one push
    pulses[0] = 0;
    cpu_cyc(2'b01, 2'b00, 8'h42);
    push_exp(0, 8'h42);
    for (int k = 0; k < 5; k++) cpu_cyc(2'b00, 2'b01, 8'h00);
    cpu_cyc(2'b00, 2'b00, 8'h00);
    wait_idle(300);
    check("held_pulses", 32'(pulses[0]), 32'd1);

    // Full queue: 4 fit, 5th stalls the CPU until the first pop
    pulses[0] = 0;
    force_lo[0] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cpu_cyc(2'b01, 2'b00, 8'hA0 + 8'(k));
      push_exp(0, 8'hA0 + 8'(k));
      cpu_cyc(2'b00, 2'b01, 8'h00);
      cpu_cyc(2'b00, 2'b00, 8'h00);
    end
    check("full_nowait", 32'(cpu_wait), 32'h0);
    cpu_cyc(2'b01, 2'b00, 8'hA4);
    push_exp(0, 8'hA4);
    latch_cs = 2'b00;
    trig_cs  = 2'b01;
    cpu_cen  = 1'b1;
    #1;
    check("full_wait_comb", 32'(cpu_wait), 32'h1);
    tick();
    cpu_cen = 1'b0;
    tick();
    tick();
    check("full_wait_held", 32'(cpu_wait), 32'h1);
    check("full_busy", 32'(busy[0]), 32'h1);
    check("full_nopulse", 32'(pulses[0]), 32'd0);
    force_lo[0] = 1'b0;
    tick();
    check("full_wait_drop", 32'(cpu_wait), 32'h0);
    check("full_first_pop", 32'(pulses[0]), 32'd1);
    trig_cs = 2'b00;
    cpu_cyc(2'b00, 2'b00, 8'h00);
    wait_idle(1000);
    check("full_pulses", 32'(pulses[0]), 32'd5);
    check("full_sb", 32'(exp0.size()), 32'd0);

    // Both chips triggered together
    pulses[0] = 0;
    pulses[1] = 0;
    cpu_cyc(2'b01, 2'b00, 8'hA1);
    cpu_cyc(2'b10, 2'b00, 8'hB2);
    push_exp(0, 8'hA1);
    push_exp(1, 8'hB2);
    latch_cs = 2'b00;
    trig_cs  = 2'b11;
    cpu_cen  = 1'b1;
    #1;
    check("dual_wait", 32'(cpu_wait), 32'h0);
    tick();
    cpu_cen = 1'b0;
    both_low = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (psg_wrn == 2'b00) both_low = 1'b1;
    end
    check("dual_parallel", 32'(both_low), 32'h1);
    cpu_cyc(2'b00, 2'b00, 8'h00);
    wait_idle(300);
    check("dual_pulses", 32'(pulses[0] + pulses[1]), 32'd2);

    // Reset mid-handshake with two entries still queued
    force_hi[0] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cpu_cyc(2'b01, 2'b00, 8'h21 + 8'(k));
      push_exp(0, 8'h21 + 8'(k));
      cpu_cyc(2'b00, 2'b01, 8'h00);
      cpu_cyc(2'b00, 2'b00, 8'h00);
    end
    check("mid_wrn_low", 32'(psg_wrn[0]), 32'h0);
    rst = 1'b1;
    #1;
    check("mid_rst_wrn", 32'(psg_wrn), 32'h3);
    check("mid_rst_busy", 32'(busy), 32'h0);
    exp0.delete();
    exp1.delete();
    force_hi[0] = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    pulses[0] = 0;
    pulses[1] = 0;
    for (int k = 0; k < 80; k++) tick();
    check("mid_no_writes", 32'(pulses[0] + pulses[1]), 32'd0);
    check("mid_busy", 32'(busy), 32'h0);

`ifdef JTKICKER_PSGTOUT_EN
    // Ready stuck high: timeout after 255 clk
    force_hi[0] = 1'b1;
    cpu_cyc(2'b01, 2'b00, 8'h66);
    push_exp(0, 8'h66);
    trig_cs = 2'b01;
    cpu_cen = 1'b1;
    tick();
    cpu_cen = 1'b0;
    n = 0;
    while (psg_wrn[0] && n < 10) begin tick(); n++; end
    n = 0;
    while (!err[0] && n < 400) begin tick(); n++; end
    check("tout_clk", 32'(n), 32'd255);
    check("tout_wrn", 32'(psg_wrn[0]), 32'h1);
    force_hi[0] = 1'b0;
    trig_cs = 2'b00;
    cpu_cyc(2'b00, 2'b00, 8'h00);
    wait_idle(300);
    check("tout_err_sticky", 32'(err), 32'h1);
`else
    // No timeout logic: ready stuck high leaves err low
    force_hi[0] = 1'b1;
    cpu_cyc(2'b01, 2'b00, 8'h66);
    push_exp(0, 8'h66);
    cpu_cyc(2'b00, 2'b01, 8'h00);
    for (int k = 0; k < 300; k++) tick();
    check("notout_wrn", 32'(psg_wrn[0]), 32'h0);
    check("notout_err", 32'(err), 32'h0);
    force_hi[0] = 1'b0;
    cpu_cyc(2'b00, 2'b00, 8'h00);
    wait_idle(300);
`endif

    check("final_sb", 32'(exp0.size() + exp1.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
